// File: rtl/riscv_v_arith_issue_ctrl.sv
// Issue controller for the vector arithmetic ALU: splits an op into DATA_W chunks,
// fetches operands, drives the ALU and writes back results (reductions accumulate).
module riscv_v_arith_issue_ctrl #(
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned MAX_CHUNKS = 8,
    parameter int unsigned ALU_LAT    = 1,
    localparam int unsigned CNT_W     = $clog2(MAX_CHUNKS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        op_code,
    input  logic [1:0]        op_osize,
    input  logic              op_signed,
    input  logic              op_reduct,
    input  logic [CNT_W-1:0]  op_chunks,
    output logic              rd_req,
    output logic [CNT_W-1:0]  rd_idx,
    input  logic [DATA_W-1:0] rd_srca,
    input  logic [DATA_W-1:0] rd_srcb,
    output logic [DATA_W-1:0] alu_srca,
    output logic [DATA_W-1:0] alu_srcb,
    output logic              alu_is_add,
    output logic              alu_is_sub,
    output logic              alu_is_min,
    output logic              alu_is_max,
    output logic              alu_is_set_equal,
    output logic              alu_is_set_nequal,
    output logic              alu_is_set_less,
    output logic              alu_is_set_greater,
    output logic              alu_is_signed,
    output logic              alu_is_reduct,
    output logic [1:0]        alu_osize,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zf,
    input  logic              alu_cf,
    input  logic              alu_of,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [CNT_W-1:0]  wb_idx,
    output logic [DATA_W-1:0] wb_data,
    output logic [2:0]        wb_flags,
    output logic              done
);
    localparam int unsigned LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WAIT, S_EXEC, S_WB, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]  idx_q, nchk_q;
    logic [2:0]        code_q;
    logic [1:0]        osize_q;
    logic              sgn_q, red_q;
    logic [DATA_W-1:0] srca_q, srcb_q, acc_q, res_q;
    logic [2:0]        flags_q;
    logic [LAT_W-1:0]  lat_q;

    logic [CNT_W-1:0]  idx_inc_c;
    logic              last_chunk_c, exec_last_c, wb_write_c;

    assign idx_inc_c    = idx_q + CNT_W'(1);
    assign last_chunk_c = (idx_inc_c >= nchk_q);
    assign exec_last_c  = (lat_q == LAT_W'(ALU_LAT - 1));
    // Reductions only write back once, on the final chunk.
    assign wb_write_c   = !red_q || last_chunk_c;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt          = state;
        op_ready           = 1'b0;
        rd_req             = 1'b0;
        rd_idx             = '0;
        alu_srca           = '0;
        alu_srcb           = '0;
        alu_is_add         = 1'b0;
        alu_is_sub         = 1'b0;
        alu_is_min         = 1'b0;
        alu_is_max         = 1'b0;
        alu_is_set_equal   = 1'b0;
        alu_is_set_nequal  = 1'b0;
        alu_is_set_less    = 1'b0;
        alu_is_set_greater = 1'b0;
        alu_is_signed      = 1'b0;
        alu_is_reduct      = 1'b0;
        alu_osize          = 2'b00;
        wb_valid           = 1'b0;
        wb_idx             = '0;
        wb_data            = '0;
        wb_flags           = 3'b000;
        done               = 1'b0;
        case (state)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) state_nxt = (op_chunks == '0) ? S_DONE : S_READ;
            end
            S_READ: begin
                rd_req    = 1'b1;
                rd_idx    = idx_q;
                state_nxt = S_WAIT;
            end
            S_WAIT: state_nxt = S_EXEC;
            S_EXEC: begin
                alu_srca           = srca_q;
                alu_srcb           = (red_q && idx_q != '0) ? acc_q : srcb_q;
                alu_is_add         = (code_q == 3'd0);
                alu_is_sub         = (code_q == 3'd1);
                alu_is_min         = (code_q == 3'd2);
                alu_is_max         = (code_q == 3'd3);
                alu_is_set_equal   = (code_q == 3'd4);
                alu_is_set_nequal  = (code_q == 3'd5);
                alu_is_set_less    = (code_q == 3'd6);
                alu_is_set_greater = (code_q == 3'd7);
                alu_is_signed      = sgn_q;
                alu_is_reduct      = red_q;
                alu_osize          = osize_q;
                if (exec_last_c) state_nxt = S_WB;
            end
            S_WB: begin
                if (wb_write_c) begin
                    wb_valid = 1'b1;
                    wb_idx   = red_q ? '0 : idx_q;
                    wb_data  = res_q;
                    wb_flags = flags_q;
                    if (wb_ready) state_nxt = last_chunk_c ? S_DONE : S_READ;
                end else begin
                    state_nxt = S_READ;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Op latch, operand capture, result sampling and chunk/accumulator bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            nchk_q  <= '0;
            code_q  <= 3'b000;
            osize_q <= 2'b00;
            sgn_q   <= 1'b0;
            red_q   <= 1'b0;
            srca_q  <= '0;
            srcb_q  <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            flags_q <= 3'b000;
            lat_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        idx_q   <= '0;
                        nchk_q  <= (op_chunks > CNT_W'(MAX_CHUNKS)) ? CNT_W'(MAX_CHUNKS) : op_chunks;
                        code_q  <= op_code;
                        osize_q <= op_osize;
                        sgn_q   <= op_signed;
                        red_q   <= op_reduct;
                    end
                end
                S_WAIT: begin
                    srca_q <= rd_srca;
                    srcb_q <= rd_srcb;
                    lat_q  <= '0;
                end
                S_EXEC: begin
                    if (exec_last_c) begin
                        res_q   <= alu_result;
                        flags_q <= {alu_cf, alu_of, alu_zf};
                    end else begin
                        lat_q <= lat_q + LAT_W'(1);
                    end
                end
                S_WB: begin
                    if (!wb_write_c) begin
                        acc_q <= res_q;
                        idx_q <= idx_inc_c;
                    end else if (wb_ready) begin
                        idx_q <= idx_inc_c;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_v_arith_issue_ctrl.sv
// Directed bench for riscv_v_arith_issue_ctrl with a VRF read model and a small
// combinational ALU model; expected values are hand-computed constants.
module tb_riscv_v_arith_issue_ctrl;
    localparam int unsigned DW  = 128;
    localparam int unsigned MC  = 8;
    localparam int unsigned LAT = 1;
    localparam int unsigned CW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          op_valid, op_ready;
    logic [2:0]    op_code;
    logic [1:0]    op_osize;
    logic          op_signed, op_reduct;
    logic [CW-1:0] op_chunks;
    logic          rd_req;
    logic [CW-1:0] rd_idx;
    logic [DW-1:0] rd_srca, rd_srcb;
    logic [DW-1:0] alu_srca, alu_srcb;
    logic          alu_is_add, alu_is_sub, alu_is_min, alu_is_max;
    logic          alu_is_set_equal, alu_is_set_nequal, alu_is_set_less, alu_is_set_greater;
    logic          alu_is_signed, alu_is_reduct;
    logic [1:0]    alu_osize;
    logic [DW-1:0] alu_result;
    logic          alu_zf, alu_cf, alu_of;
    logic          wb_valid, wb_ready;
    logic [CW-1:0] wb_idx;
    logic [DW-1:0] wb_data;
    logic [2:0]    wb_flags;
    logic          done;

    always #5 clk = ~clk;

    riscv_v_arith_issue_ctrl #(.DATA_W(DW), .MAX_CHUNKS(MC), .ALU_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_osize(op_osize),
        .op_signed(op_signed), .op_reduct(op_reduct), .op_chunks(op_chunks),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_srca(rd_srca), .rd_srcb(rd_srcb),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb),
        .alu_is_add(alu_is_add), .alu_is_sub(alu_is_sub), .alu_is_min(alu_is_min),
        .alu_is_max(alu_is_max), .alu_is_set_equal(alu_is_set_equal),
        .alu_is_set_nequal(alu_is_set_nequal), .alu_is_set_less(alu_is_set_less),
        .alu_is_set_greater(alu_is_set_greater), .alu_is_signed(alu_is_signed),
        .alu_is_reduct(alu_is_reduct), .alu_osize(alu_osize),
        .alu_result(alu_result), .alu_zf(alu_zf), .alu_cf(alu_cf), .alu_of(alu_of),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_idx(wb_idx), .wb_data(wb_data),
        .wb_flags(wb_flags), .done(done)
    );

    // VRF: data valid only the cycle after rd_req, garbage otherwise.
    logic [DW-1:0] mem_a [MC];
    logic [DW-1:0] mem_b [MC];
    always @(posedge clk) begin
        if (rd_req) begin
            rd_srca <= mem_a[rd_idx[2:0]];
            rd_srcb <= mem_b[rd_idx[2:0]];
        end else begin
            rd_srca <= {4{32'hDEAD_BEEF}};
            rd_srcb <= {4{32'hBAD0_F00D}};
        end
    end

    // ALU model (single-cycle): cf mirrors sub, of mirrors signed, zf on zero result.
    always_comb begin
        alu_result = '0;
        if (alu_is_add)           alu_result = alu_srca + alu_srcb;
        else if (alu_is_sub)      alu_result = alu_srca - alu_srcb;
        else if (alu_is_set_less) alu_result = DW'(alu_is_signed ?
                                      ($signed(alu_srca[7:0]) < $signed(alu_srcb[7:0])) :
                                      (alu_srca[7:0] < alu_srcb[7:0]));
        alu_zf = (alu_result == '0);
        alu_cf = alu_is_sub;
        alu_of = alu_is_signed;
    end

    int cyc, wb_cnt, rd_cnt, done_cnt, exec_cnt, acc_cyc, done_cyc;
    logic [DW-1:0] wb_data_log  [64];
    logic [CW-1:0] wb_idx_log   [64];
    logic [2:0]    wb_flags_log [64];
    logic [DW-1:0] exec_b_log   [64];
    logic [7:0]    last_vec;
    logic          last_sgn;
    logic [1:0]    last_osize;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wb_valid && wb_ready) begin
            if (wb_cnt < 64) begin
                wb_data_log[wb_cnt]  <= wb_data;
                wb_idx_log[wb_cnt]   <= wb_idx;
                wb_flags_log[wb_cnt] <= wb_flags;
            end
            wb_cnt <= wb_cnt + 1;
        end
        if (rd_req) rd_cnt <= rd_cnt + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (op_valid && op_ready) acc_cyc <= cyc;
        if (alu_is_add | alu_is_sub | alu_is_min | alu_is_max | alu_is_set_equal |
            alu_is_set_nequal | alu_is_set_less | alu_is_set_greater) begin
            if (exec_cnt < 64) exec_b_log[exec_cnt] <= alu_srcb;
            exec_cnt   <= exec_cnt + 1;
            last_vec   <= {alu_is_set_greater, alu_is_set_less, alu_is_set_nequal, alu_is_set_equal,
                           alu_is_max, alu_is_min, alu_is_sub, alu_is_add};
            last_sgn   <= alu_is_signed;
            last_osize <= alu_osize;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] code, input logic [1:0] osz, input logic sgn,
                         input logic red, input logic [CW-1:0] n);
        @(posedge clk) #1;
        op_valid  = 1'b1;
        op_code   = code;
        op_osize  = osz;
        op_signed = sgn;
        op_reduct = red;
        op_chunks = n;
        @(posedge clk) #1;
        op_valid  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done_cnt != base) break;
        end
        check(tag, DW'(done_cnt - base), DW'(1));
    endtask

    int b_wb, b_rd, b_dn, b_ex, seen;
    logic stable;

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_code = 3'd0; op_osize = 2'd0;
        op_signed = 1'b0; op_reduct = 1'b0; op_chunks = '0; wb_ready = 1'b1;
        for (int i = 0; i < int'(MC); i++) begin mem_a[i] = '0; mem_b[i] = '0; end
        repeat (2) @(negedge clk);
        check("rst_op_ready", DW'(op_ready), DW'(1));
        check("rst_rd_req",   DW'(rd_req),   DW'(0));
        check("rst_wb_valid", DW'(wb_valid), DW'(0));
        check("rst_done",     DW'(done),     DW'(0));
        check("rst_alu_add",  DW'(alu_is_add), DW'(0));
        @(posedge clk) #1 rst = 1'b0;

        // ADD, 2 chunks
        mem_a[0] = DW'(1); mem_a[1] = DW'(2); mem_b[0] = DW'(10); mem_b[1] = DW'(20);
        b_wb = wb_cnt; b_dn = done_cnt;
        issue(3'd0, 2'd2, 1'b0, 1'b0, CW'(2));
        wait_done("add_done", b_dn);
        check("add_wb_cnt", DW'(wb_cnt - b_wb), DW'(2));
        check("add_idx0",   DW'(wb_idx_log[b_wb]),     DW'(0));
        check("add_data0",  wb_data_log[b_wb],         DW'(11));
        check("add_idx1",   DW'(wb_idx_log[b_wb+1]),   DW'(1));
        check("add_data1",  wb_data_log[b_wb+1],       DW'(22));
        check("add_flags",  DW'(wb_flags_log[b_wb+1]), DW'(0));
        check("add_latency", DW'(done_cyc - acc_cyc), DW'(1 + 2 * (3 + LAT)));

        // Reduction ADD, 3 chunks: 1+100=101, 2+101=103, 3+103=106
        mem_a[0] = DW'(1);   mem_a[1] = DW'(2);   mem_a[2] = DW'(3);
        mem_b[0] = DW'(100); mem_b[1] = DW'(200); mem_b[2] = DW'(300);
        b_wb = wb_cnt; b_dn = done_cnt; b_ex = exec_cnt;
        issue(3'd0, 2'd3, 1'b0, 1'b1, CW'(3));
        wait_done("red_done", b_dn);
        check("red_wb_cnt", DW'(wb_cnt - b_wb), DW'(1));
        check("red_wb_idx", DW'(wb_idx_log[b_wb]), DW'(0));
        check("red_wb_data", wb_data_log[b_wb], DW'(106));
        check("red_srcb0", exec_b_log[b_ex],   DW'(100));
        check("red_srcb1", exec_b_log[b_ex+1], DW'(101));
        check("red_srcb2", exec_b_log[b_ex+2], DW'(103));

        // Write-back back-pressure for 5 cycles on chunk 0
        mem_a[0] = DW'(5); mem_a[1] = DW'(6); mem_b[0] = DW'(7); mem_b[1] = DW'(8);
        wb_ready = 1'b0;
        b_wb = wb_cnt; b_dn = done_cnt;
        issue(3'd0, 2'd0, 1'b0, 1'b0, CW'(2));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wb_valid) begin seen = 1; break; end
        end
        check("stall_wb_seen", DW'(seen), DW'(1));
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            stable &= wb_valid && (wb_data == DW'(12)) && (wb_idx == '0) && !rd_req;
        end
        check("stall_hold", DW'(stable), DW'(1));
        @(posedge clk) #1 wb_ready = 1'b1;
        wait_done("stall_done", b_dn);
        check("stall_wb_cnt", DW'(wb_cnt - b_wb), DW'(2));
        check("stall_data0", wb_data_log[b_wb],   DW'(12));
        check("stall_data1", wb_data_log[b_wb+1], DW'(14));

        // Zero-chunk op
        b_wb = wb_cnt; b_dn = done_cnt; b_rd = rd_cnt;
        issue(3'd0, 2'd0, 1'b0, 1'b0, CW'(0));
        wait_done("zero_done", b_dn);
        check("zero_rd",  DW'(rd_cnt - b_rd), DW'(0));
        check("zero_wb",  DW'(wb_cnt - b_wb), DW'(0));
        check("zero_latency", DW'(done_cyc - acc_cyc), DW'(1));

        // Reset during EXEC of chunk 1
        mem_a[0] = DW'(1); mem_a[1] = DW'(2); mem_b[0] = DW'(10); mem_b[1] = DW'(20);
        issue(3'd0, 2'd0, 1'b0, 1'b0, CW'(2));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (alu_is_add) begin
                seen++;
                if (seen == 2) break;
            end
        end
        check("mid_exec_seen", DW'(seen), DW'(2));
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_op_ready", DW'(op_ready), DW'(1));
        check("mid_rst_wb_valid", DW'(wb_valid), DW'(0));
        check("mid_rst_done",     DW'(done),     DW'(0));
        b_wb = wb_cnt; b_dn = done_cnt; b_rd = rd_cnt;
        @(posedge clk) #1 rst = 1'b0;
        repeat (8) @(negedge clk);
        check("mid_rst_no_done", DW'(done_cnt - b_dn), DW'(0));
        check("mid_rst_no_wb",   DW'(wb_cnt - b_wb),   DW'(0));
        check("mid_rst_no_rd",   DW'(rd_cnt - b_rd),   DW'(0));

        // SLT signed 8b: -1 < 0
        mem_a[0] = DW'(8'hFF); mem_b[0] = DW'(0);
        b_wb = wb_cnt; b_dn = done_cnt;
        issue(3'd6, 2'd0, 1'b1, 1'b0, CW'(1));
        wait_done("slt_done", b_dn);
        check("slt_onehot", DW'(last_vec),   DW'(8'b0100_0000));
        check("slt_signed", DW'(last_sgn),   DW'(1));
        check("slt_osize",  DW'(last_osize), DW'(0));
        check("slt_data",   wb_data_log[b_wb], DW'(1));
        check("slt_flags",  DW'(wb_flags_log[b_wb]), DW'(3'b010));

        // Chunk count above MAX_CHUNKS is clamped
        for (int i = 0; i < int'(MC); i++) begin mem_a[i] = DW'(i + 1); mem_b[i] = '0; end
        b_wb = wb_cnt; b_dn = done_cnt;
        issue(3'd0, 2'd0, 1'b0, 1'b0, CW'(12));
        wait_done("clamp_done", b_dn);
        check("clamp_wb_cnt",   DW'(wb_cnt - b_wb), DW'(8));
        check("clamp_last_idx", DW'(wb_idx_log[b_wb+7]), DW'(7));
        check("clamp_last_data", wb_data_log[b_wb+7], DW'(8));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
